// File: rtl/i2c_multi_addr_decoder_if.sv
// Bus-side signals of the multi-address I2C decoder: sampled SCL/SDA, control
// strobes from the START/STOP detector, and the decode result.
interface i2c_multi_addr_decoder_if;
    logic       SCL;
    logic       SCL_prev;
    logic       SDA;
    logic       enable;
    logic       start;
    logic       done;
    logic       selected;
    logic [2:0] match_idx;
    logic       rw;
    logic       gen_call;

    modport slave (
        input  SCL, SCL_prev, SDA, enable, start,
        output done, selected, match_idx, rw, gen_call
    );

    modport master (
        output SCL, SCL_prev, SDA, enable, start,
        input  done, selected, match_idx, rw, gen_call
    );
endinterface

// File: rtl/i2c_multi_addr_decoder.sv
// I2C slave address-phase decoder with NUM_ADDR programmable 7/10-bit slots,
// general call, R/W capture and the 10-bit repeated-start read header.
module i2c_multi_addr_decoder #(
    parameter int NUM_ADDR = 4,
    parameter bit GC_EN    = 1'b1
) (
    input  logic                     FPGA_clk,
    input  logic                     rst_n,
    i2c_multi_addr_decoder_if.slave  bus,
    input  logic [NUM_ADDR*10-1:0]   addr_list,
    input  logic [NUM_ADDR-1:0]      addr_is10,
    input  logic [NUM_ADDR-1:0]      slot_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTE1 = 2'd1,
        S_BYTE2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] lowest_idx(input logic [7:0] mask);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) lowest_idx = 3'(i);
        end
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_bit_cnt;
    logic [NUM_ADDR-1:0] r_alive;
    logic                r_gc_alive;
    logic                r_hdr10_armed;
    logic [2:0]          r_armed_idx;
    logic                r_done;
    logic                r_selected;
    logic [2:0]          r_match_idx;
    logic                r_rw;
    logic                r_gen_call;

    logic                w_strobe;
    logic                w_last;
    logic [2:0]          w_bit_pos;
    logic [7:0]          w_exp [NUM_ADDR];
    logic [NUM_ADDR-1:0] w_bit_ok;
    logic [NUM_ADDR-1:0] w_alive_upd;
    logic [NUM_ADDR-1:0] w_7b_alive;
    logic [NUM_ADDR-1:0] w_hdr_alive;
    logic [7:0]          w_hdr8;
    logic                w_gc_upd;
    logic                w_sel7;
    logic                w_selgc;
    logic                w_selrd;
    logic                w_go_b2;
    logic                w_early_miss;

    logic                w_done_n;
    logic                w_selected_n;
    logic [2:0]          w_match_idx_n;
    logic                w_rw_n;
    logic                w_gen_call_n;
    logic                w_armed_n;
    logic [2:0]          w_armed_idx_n;

    assign w_strobe  = bus.SCL & ~bus.SCL_prev;
    assign w_last    = (r_bit_cnt == 3'd7);
    assign w_bit_pos = 3'd7 - r_bit_cnt;

    // Per-slot expected byte: header/7-bit address in BYTE1, low address byte in BYTE2.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_bit_ok = '0;
        for (int k = 0; k < NUM_ADDR; k++) begin
            if (r_state == S_BYTE2)
                w_exp[k] = addr_list[k*10 +: 8];
            else if (addr_is10[k])
                w_exp[k] = {5'b11110, addr_list[k*10+8 +: 2], 1'b0};
            else
                w_exp[k] = {addr_list[k*10 +: 7], 1'b0};
            // The R/W bit of BYTE1 never filters slots.
            w_bit_ok[k] = (w_exp[k][w_bit_pos] == bus.SDA) ||
                          ((r_state == S_BYTE1) && w_last);
        end
        w_alive_upd  = r_alive & w_bit_ok;
        w_gc_upd     = r_gc_alive & (~bus.SDA | w_last);
        w_7b_alive   = w_alive_upd & ~addr_is10;
        w_hdr_alive  = w_alive_upd & addr_is10;
        w_hdr8       = 8'(w_hdr_alive);
        w_sel7       = |w_7b_alive;
        w_selgc      = w_gc_upd & ~bus.SDA & ~w_sel7;
        w_go_b2      = ~w_sel7 & ~w_selgc & (|w_hdr_alive) & ~bus.SDA;
        w_selrd      = ~w_sel7 & bus.SDA & r_hdr10_armed & w_hdr8[r_armed_idx];
        w_early_miss = (w_alive_upd == '0) & ~w_gc_upd;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge FPGA_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        if (!bus.enable) begin
            w_next_state = S_IDLE;
        end else if (bus.start) begin
            w_next_state = S_BYTE1;
        end else if (w_strobe) begin
            case (r_state)
                S_BYTE1: begin
                    if (w_last)            w_next_state = w_go_b2 ? S_BYTE2 : S_DONE;
                    else if (w_early_miss) w_next_state = S_DONE;
                end
                S_BYTE2: begin
                    if (w_last || w_early_miss) w_next_state = S_DONE;
                end
                default: ;
            endcase
        end
    end

    // Next values of the registered decode result and the 10-bit read arm.
    always_comb begin
        w_done_n      = r_done;
        w_selected_n  = r_selected;
        w_match_idx_n = r_match_idx;
        w_rw_n        = r_rw;
        w_gen_call_n  = r_gen_call;
        w_armed_n     = r_hdr10_armed;
        w_armed_idx_n = r_armed_idx;
        if (!bus.enable) begin
            w_done_n      = 1'b0;
            w_selected_n  = 1'b0;
            w_match_idx_n = 3'd0;
            w_rw_n        = 1'b0;
            w_gen_call_n  = 1'b0;
            w_armed_n     = 1'b0;
            w_armed_idx_n = 3'd0;
        end else if (bus.start) begin
            w_done_n      = 1'b0;
            w_selected_n  = 1'b0;
            w_match_idx_n = 3'd0;
            w_rw_n        = 1'b0;
            w_gen_call_n  = 1'b0;
        end else if (w_strobe) begin
            case (r_state)
                S_BYTE1: begin
                    if (w_last) begin
                        // Any BYTE1 outcome other than the armed read re-selecting disarms.
                        w_armed_n = 1'b0;
                        w_done_n  = ~w_go_b2;
                        if (w_sel7) begin
                            w_selected_n  = 1'b1;
                            w_match_idx_n = lowest_idx(8'(w_7b_alive));
                            w_rw_n        = bus.SDA;
                        end else if (w_selgc) begin
                            w_selected_n  = 1'b1;
                            w_gen_call_n  = 1'b1;
                        end else if (w_selrd) begin
                            w_selected_n  = 1'b1;
                            w_match_idx_n = r_armed_idx;
                            w_rw_n        = 1'b1;
                            w_armed_n     = 1'b1;
                        end
                    end else if (w_early_miss) begin
                        w_done_n  = 1'b1;
                        w_armed_n = 1'b0;
                    end
                end
                S_BYTE2: begin
                    if (w_early_miss) begin
                        w_done_n = 1'b1;
                    end else if (w_last) begin
                        w_done_n      = 1'b1;
                        w_selected_n  = 1'b1;
                        w_match_idx_n = lowest_idx(w_hdr8);
                        w_rw_n        = 1'b0;
                        w_armed_n     = 1'b1;
                        w_armed_idx_n = lowest_idx(w_hdr8);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge FPGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt     <= 3'd0;
            r_alive       <= '0;
            r_gc_alive    <= 1'b0;
            r_hdr10_armed <= 1'b0;
            r_armed_idx   <= 3'd0;
            r_done        <= 1'b0;
            r_selected    <= 1'b0;
            r_match_idx   <= 3'd0;
            r_rw          <= 1'b0;
            r_gen_call    <= 1'b0;
        end else begin
            r_hdr10_armed <= w_armed_n;
            r_armed_idx   <= w_armed_idx_n;
            r_done        <= w_done_n;
            r_selected    <= w_selected_n;
            r_match_idx   <= w_match_idx_n;
            r_rw          <= w_rw_n;
            r_gen_call    <= w_gen_call_n;
            if (!bus.enable) begin
                r_bit_cnt  <= 3'd0;
                r_alive    <= '0;
                r_gc_alive <= 1'b0;
            end else if (bus.start) begin
                r_bit_cnt  <= 3'd0;
                r_alive    <= slot_en;
                r_gc_alive <= GC_EN;
            end else if (w_strobe && (r_state == S_BYTE1 || r_state == S_BYTE2)) begin
                // Counter wraps to 0 on the BYTE1->BYTE2 hand-over.
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_alive    <= w_alive_upd;
                r_gc_alive <= (r_state == S_BYTE1 && !w_last) ? w_gc_upd : 1'b0;
            end
        end
    end

    assign bus.done      = r_done;
    assign bus.selected  = r_selected;
    assign bus.match_idx = r_match_idx;
    assign bus.rw        = r_rw;
    assign bus.gen_call  = r_gen_call;

endmodule
